accumulator_bank: RTL
=====================

# accumulator_bank

Parametrised, addressable, double-buffered accumulator storage between the systolic array's column outputs and the post-processing stage (activation/quantise). Each bank holds DEPTH rows of COLS signed accumulators. The array writes one bank in overwrite or accumulate mode while the other bank drains over a valid/ready stream. Drained rows self-clear, and bank roles swap automatically at tile boundaries.

## Interface
- COLS, default 3: columns per row
- IN_W, default 32: signed input width per column
- ACC_W, default 32: signed accumulator width per column, ACC_W >= IN_W
- DEPTH, default 8: rows per bank, >= 2
- SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- wr_valid  in  1  write beat present
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready
- wr_row  in  $clog2(DEPTH)  target row in the write bank
- wr_mode  in  1  0 = overwrite, 1 = accumulate
- wr_last  in  1  final beat of the tile; commits the write bank
- wr_data  in  COLS*IN_W  column c in bits [c*IN_W +: IN_W], signed
- rd_valid  out  1  drain beat present
- rd_ready  in  1  consumer accepts the beat
- rd_row  out  $clog2(DEPTH)  row index of the current beat
- rd_last  out  1  high on the beat for row DEPTH-1
- rd_data  out  COLS*ACC_W  signed accumulators, same packing
- wr_bank  out  1  index of the bank currently being written
- sat_sticky  out  1  any column saturated or wrapped since last clear
- sat_clear  in  1  clears sat_sticky

## Operation
- Storage: 2 x DEPTH x COLS registers of ACC_W bits. The write side addresses bank wr_bank only. The read side addresses bank !wr_bank only. The two sides never alias.
- Write, on an accepted beat:
  - Overwrite: row <= sign-extend(wr_data).
  - Accumulate: row <= row + sign-extend(wr_data).
  - Sum is formed at ACC_W+1 bits.
  - SATURATE=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=0: truncate.
  - Either way, any overflow sets sat_sticky.
- wr_row >= DEPTH: data is dropped and wr_last is still honoured.
- Read FSM states are R_IDLE and R_DRAIN.
  - In R_DRAIN: rd_valid=1, rd_row = drain counter, rd_data is driven combinationally from the read bank.
  - On each accepted beat, the row is zeroed and the counter advances.
  - The beat with rd_last accepted returns the FSM to R_IDLE.
- Commit, on an accepted wr_last beat:
  - If read FSM is R_IDLE, or is accepting its rd_last beat this same cycle: swap at this edge. wr_bank toggles, drain counter is set to 0, FSM enters R_DRAIN.
  - Otherwise: set commit_pending and deassert wr_ready.
  - The swap then happens at the edge where rd_last is accepted.
- Because drained rows self-clear, a fresh write bank reads as zero. The first accumulate of a tile therefore starts from 0.
- sat_sticky: a set event and sat_clear in the same cycle leaves it set (set wins).

## Timing
- Reset values:
  - all storage 0
  - wr_bank=0
  - FSM R_IDLE, rd_valid=0, rd_row=0, rd_last=0
  - rd_data=0
  - wr_ready=1
  - sat_sticky=0
  - commit_pending=0
- Reset mid-operation discards all partial sums and pending commits.
- Write-to-storage latency is 1 cycle. Back-to-back accumulates to the same row each see the previous result, with no bubble.
- Swap edge to first rd_valid: 1 cycle. The wr_last data is visible on rd_data at that first beat.
- Drain takes DEPTH cycles with rd_ready held high. rd_data and rd_row stay stable while rd_valid && !rd_ready.
- wr_ready:
  - falls the cycle after a pending commit is taken;
  - rises the cycle after the swap edge.
- wr_ready does not depend combinationally on wr_valid or wr_last.

## Structure
- Package accum_pkg:
  - acc_mode_e {ACC_OVERWRITE, ACC_ACCUMULATE}
  - rd_state_e {R_IDLE, R_DRAIN}
  - function sat_add(a, b, saturate), returning sum and an overflow flag
- One sub-module, accum_lane: combinational per-column mode select, extend, add and saturate. It is instantiated COLS times in a generate loop.
- Storage, the read FSM and the commit logic live in accumulator_bank.

## Test plan
1. Overwrite, then drain:
   - Stimulus: overwrite rows 0..7 with column c = 10*row+c; last beat has wr_last; rd_ready=1.
   - Response: 8 beats, rows 0..7, row 5 = {50,51,52}, rd_last on row 7, wr_bank=1 after.
2. Accumulate across tiles:
   - Stimulus: accumulate 3 to row 2 four times in tile A, then write tile B.
   - Response: tile A drains row 2 = 12; a later tile B accumulate of 1 to row 2 reads 1, confirming clear-on-drain.
3. Saturation, SATURATE=1:
   - Stimulus: overwrite 0x7FFFFFF0, then accumulate 0x20.
   - Response: 0x7FFFFFFF, sat_sticky=1. sat_clear with no new overflow clears it.
4. Wrap, SATURATE=0:
   - Stimulus: same inputs as scenario 3.
   - Response: 0x80000010, sat_sticky=1.
5. Backpressure and pending commit:
   - Stimulus: rd_ready=0 while a second tile's wr_last arrives.
   - Response: wr_ready=0 the next cycle; rd_data stable. Raising rd_ready drains 8 beats, the swap occurs on the rd_last edge, and wr_ready=1 one cycle later.
6. Simultaneous events and reset:
   - wr_last accepted on the same edge as rd_last: immediate swap, wr_ready never drops.
   - rst_n low mid-drain: all outputs return to reset values, and a subsequent drain of an unwritten bank yields zeros.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and the saturating adder used by the accumulator bank lanes.
package accum_pkg;

  typedef enum logic {ACC_OVERWRITE, ACC_ACCUMULATE} acc_mode_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  // Wide enough for any ACC_W up to 63 plus the carry bit.
  localparam int SUM_W = 64;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input int                      acc_w,
                                       input logic                    saturate);
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sat_res_t                r;
    s     = a + b;
    hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo    = ~hi;
    r.ovf = (s > hi) || (s < lo);
    r.sum = s;
    if (saturate && (s > hi)) r.sum = hi;
    else if (saturate && (s < lo)) r.sum = lo;
    return r;
  endfunction

endpackage

// File: rtl/accumulator_bank_lane.sv
// One column of the write datapath: overwrite or accumulate with clamp/wrap.
module accum_lane
  import accum_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  acc_mode_e               mode,
  input  logic signed [IN_W-1:0]  din,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  sat_res_t sum_r;
  logic     unused_hi;

  assign sum_r     = sat_add(SUM_W'(acc), SUM_W'(din), ACC_W, SATURATE != 0);
  assign unused_hi = ^sum_r.sum[SUM_W-1:ACC_W];

  always_comb begin
    result = ACC_W'(din);
    ovf    = 1'b0;
    if (mode == ACC_ACCUMULATE) begin
      result = sum_r.sum[ACC_W-1:0];
      ovf    = sum_r.ovf;
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// Double-buffered accumulator storage: one bank takes array writes while the
// other drains over valid/ready; drained rows self-clear and banks swap per tile.
module accumulator_bank
  import accum_pkg::*;
#(
  parameter int COLS     = 3,
  parameter int IN_W     = 32,
  parameter int ACC_W    = 32,
  parameter int DEPTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(DEPTH)-1:0]   wr_row,
  input  logic                       wr_mode,
  input  logic                       wr_last,
  input  logic [COLS*IN_W-1:0]       wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH)-1:0]   rd_row,
  output logic                       rd_last,
  output logic [COLS*ACC_W-1:0]      rd_data,
  output logic                       wr_bank,
  output logic                       sat_sticky,
  input  logic                       sat_clear
);

  localparam int                 ROW_W    = $clog2(DEPTH);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(DEPTH - 1);

  rd_state_e               state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [ROW_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic                    commit_pending_q, commit_pending_d;
  logic                    sat_sticky_q, sat_sticky_d;
  logic signed [ACC_W-1:0] mem_q [2][DEPTH][COLS];
  logic signed [ACC_W-1:0] mem_d [2][DEPTH][COLS];

  logic                    rd_bank;
  logic                    row_ok;
  logic [ROW_W-1:0]        wr_idx;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_last_fire;
  logic signed [ACC_W-1:0] lane_res [COLS];
  logic [COLS-1:0]         lane_ovf;

  assign rd_bank      = ~wr_bank_q;
  assign row_ok       = {1'b0, wr_row} < (ROW_W + 1)'(DEPTH);
  assign wr_idx       = row_ok ? wr_row : '0;
  assign wr_fire      = wr_valid && !commit_pending_q;
  assign rd_fire      = (state_q == R_DRAIN) && rd_ready;
  assign rd_last_fire = rd_fire && (rd_cnt_q == LAST_ROW);

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    accum_lane #(
      .IN_W    (IN_W),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
    ) u_lane (
      .mode  (acc_mode_e'(wr_mode)),
      .din   (wr_data[c*IN_W +: IN_W]),
      .acc   (mem_q[wr_bank_q][wr_idx][c]),
      .result(lane_res[c]),
      .ovf   (lane_ovf[c])
    );
  end

  // Write and drain-clear always hit opposite banks, so order does not matter.
  always_comb begin
    mem_d = mem_q;
    if (wr_fire && row_ok) begin
      for (int c = 0; c < COLS; c++) mem_d[wr_bank_q][wr_idx][c] = lane_res[c];
    end
    if (rd_fire) begin
      for (int c = 0; c < COLS; c++) mem_d[rd_bank][rd_cnt_q][c] = '0;
    end
  end

  always_comb begin
    state_d          = state_q;
    rd_cnt_d         = rd_cnt_q;
    wr_bank_d        = wr_bank_q;
    commit_pending_d = commit_pending_q;
    if (rd_last_fire) begin
      state_d  = R_IDLE;
      rd_cnt_d = '0;
    end else if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + ROW_W'(1);
    end
    // A commit swaps when the read side is free now or frees up on this edge.
    if ((wr_fire && wr_last && ((state_q == R_IDLE) || rd_last_fire)) ||
        (commit_pending_q && rd_last_fire)) begin
      wr_bank_d        = ~wr_bank_q;
      rd_cnt_d         = '0;
      state_d          = R_DRAIN;
      commit_pending_d = 1'b0;
    end else if (wr_fire && wr_last) begin
      commit_pending_d = 1'b1;
    end
  end

  always_comb begin
    sat_sticky_d = (sat_sticky_q && !sat_clear) || (wr_fire && row_ok && (|lane_ovf));
  end

  always_comb begin
    rd_data = '0;
    if (state_q == R_DRAIN) begin
      for (int c = 0; c < COLS; c++) rd_data[c*ACC_W +: ACC_W] = mem_q[rd_bank][rd_cnt_q][c];
    end
  end

  assign wr_ready   = !commit_pending_q;
  assign rd_valid   = (state_q == R_DRAIN);
  assign rd_row     = rd_cnt_q;
  assign rd_last    = (state_q == R_DRAIN) && (rd_cnt_q == LAST_ROW);
  assign wr_bank    = wr_bank_q;
  assign sat_sticky = sat_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= R_IDLE;
      rd_cnt_q         <= '0;
      wr_bank_q        <= 1'b0;
      commit_pending_q <= 1'b0;
      sat_sticky_q     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < DEPTH; r++)
          for (int c = 0; c < COLS; c++) mem_q[b][r][c] <= '0;
    end else begin
      state_q          <= state_d;
      rd_cnt_q         <= rd_cnt_d;
      wr_bank_q        <= wr_bank_d;
      commit_pending_q <= commit_pending_d;
      sat_sticky_q     <= sat_sticky_d;
      mem_q            <= mem_d;
    end
  end

endmodule
